// File: rtl/intr_ctrl.sv
// Two-source interrupt controller: edge-detects key/eth lines, latches payloads,
// arbitrates (eth over key) into one registered request held until ack, then busy until done.
module intr_ctrl #(
  parameter int DATA_W = 32,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt_key,
  input  logic              interrupt_eth,
  input  logic [DATA_W-1:0] key_data,
  input  logic [DATA_W-1:0] eth_data,
  input  logic              irq_enable,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              interrupt,
  output logic [1:0]        irq_cause,
  output logic [DATA_W-1:0] interrupt_source_data,
  output logic              irq_busy,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

  state_t              state, state_nxt;
  logic                key_q, eth_q;
  logic                pend_key, pend_eth;
  logic [DATA_W-1:0]   data_key, data_eth;
  logic                ev_key, ev_eth;
  logic                clr_key, clr_eth;
  logic                drop_key, drop_eth;
  logic [1:0]          drop_inc;
  logic [DROP_W:0]     drop_sum;
  logic                int_nxt;
  logic [1:0]          cause_nxt;
  logic [DATA_W-1:0]   data_nxt;

  assign ev_key = interrupt_key & ~key_q;
  assign ev_eth = interrupt_eth & ~eth_q;

  // The served source is the one frozen in irq_cause; it is released on ack.
  assign clr_key = (state == PEND) && irq_enable && irq_ack && (irq_cause == 2'b01);
  assign clr_eth = (state == PEND) && irq_enable && irq_ack && (irq_cause == 2'b10);

  assign drop_key = ev_key & pend_key & ~clr_key;
  assign drop_eth = ev_eth & pend_eth & ~clr_eth;
  assign drop_inc = {1'b0, drop_key} + {1'b0, drop_eth};
  assign drop_sum = {1'b0, drop_count} + {{(DROP_W-1){1'b0}}, drop_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= 1'b0;
      eth_q      <= 1'b0;
      pend_key   <= 1'b0;
      pend_eth   <= 1'b0;
      data_key   <= '0;
      data_eth   <= '0;
      drop_count <= '0;
    end else begin
      key_q <= interrupt_key;
      eth_q <= interrupt_eth;
      // A new event on the source being cleared wins over the clear.
      if (ev_key) begin
        pend_key <= 1'b1;
        if (!pend_key || clr_key) data_key <= key_data;
      end else if (clr_key) begin
        pend_key <= 1'b0;
      end
      if (ev_eth) begin
        pend_eth <= 1'b1;
        if (!pend_eth || clr_eth) data_eth <= eth_data;
      end else if (clr_eth) begin
        pend_eth <= 1'b0;
      end
      drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      interrupt             <= 1'b0;
      irq_cause             <= 2'b00;
      interrupt_source_data <= '0;
    end else begin
      state                 <= state_nxt;
      interrupt             <= int_nxt;
      irq_cause             <= cause_nxt;
      interrupt_source_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (irq_enable && (pend_key || pend_eth)) state_nxt = PEND;
      PEND:    if (!irq_enable) state_nxt = IDLE;
               else if (irq_ack) state_nxt = SERVICE;
      SERVICE: if (irq_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_nxt   = interrupt;
    cause_nxt = irq_cause;
    data_nxt  = interrupt_source_data;
    case (state)
      IDLE: begin
        if (irq_enable && (pend_key || pend_eth)) begin
          int_nxt   = 1'b1;
          cause_nxt = pend_eth ? 2'b10 : 2'b01;
          data_nxt  = pend_eth ? data_eth : data_key;
        end
      end
      PEND: begin
        if (!irq_enable) begin
          int_nxt   = 1'b0;
          cause_nxt = 2'b00;
        end else if (irq_ack) begin
          int_nxt = 1'b0;
        end
      end
      SERVICE: begin
        if (irq_done) cause_nxt = 2'b00;
      end
      default: begin
        int_nxt   = 1'b0;
        cause_nxt = 2'b00;
      end
    endcase
  end

  assign irq_busy = (state == SERVICE);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed plus random stimulus for intr_ctrl, checked every cycle against a
// cycle-level reference model of the controller's rules.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt_key = 1'b0, interrupt_eth = 1'b0;
  logic [31:0] key_data = '0, eth_data = '0;
  logic        irq_enable = 1'b0, irq_ack = 1'b0, irq_done = 1'b0;
  logic        interrupt;
  logic [1:0]  irq_cause;
  logic [31:0] interrupt_source_data;
  logic        irq_busy;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  intr_ctrl #(.DATA_W(32), .DROP_W(8)) dut (
    .clk(clk), .rst(rst),
    .interrupt_key(interrupt_key), .interrupt_eth(interrupt_eth),
    .key_data(key_data), .eth_data(eth_data),
    .irq_enable(irq_enable), .irq_ack(irq_ack), .irq_done(irq_done),
    .interrupt(interrupt), .irq_cause(irq_cause),
    .interrupt_source_data(interrupt_source_data),
    .irq_busy(irq_busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = key, 1 = eth. phase 0 idle, 1 presented, 2 in handler.
  int          m_phase;
  int          m_served;
  bit          m_pend [2];
  logic [31:0] m_data [2];
  bit          m_prev [2];
  int          m_drops;
  bit          m_int;
  logic [1:0]  m_cause;
  logic [31:0] m_out;

  task automatic model_reset();
    m_phase = 0; m_served = 0; m_drops = 0;
    m_int = 0; m_cause = 2'b00; m_out = '0;
    for (int s = 0; s < 2; s++) begin
      m_pend[s] = 0; m_data[s] = '0; m_prev[s] = 0;
    end
  endtask

  task automatic model_step();
    bit          ln [2];
    logic [31:0] pl [2];
    bit          ev [2];
    bit          clr [2];
    ln[0] = interrupt_key; ln[1] = interrupt_eth;
    pl[0] = key_data;      pl[1] = eth_data;
    for (int s = 0; s < 2; s++) begin
      ev[s]  = ln[s] && !m_prev[s];
      clr[s] = 0;
    end
    if (m_phase == 0) begin
      if (irq_enable && (m_pend[0] || m_pend[1])) begin
        m_served = m_pend[1] ? 1 : 0;
        m_phase  = 1;
        m_int    = 1;
        m_cause  = (m_served == 1) ? 2'b10 : 2'b01;
        m_out    = m_data[m_served];
      end
    end else if (m_phase == 1) begin
      if (!irq_enable) begin
        m_phase = 0; m_int = 0; m_cause = 2'b00;
      end else if (irq_ack) begin
        clr[m_served] = 1; m_phase = 2; m_int = 0;
      end
    end else begin
      if (irq_done) begin
        m_phase = 0; m_cause = 2'b00;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (ev[s]) begin
        if (m_pend[s] && !clr[s]) m_drops = m_drops + 1;
        else m_data[s] = pl[s];
        m_pend[s] = 1;
      end else if (clr[s]) begin
        m_pend[s] = 0;
      end
      m_prev[s] = ln[s];
    end
    if (m_drops > 255) m_drops = 255;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".interrupt"}, interrupt, m_int);
    chk({tag, ".cause"}, irq_cause, m_cause);
    chk({tag, ".data"}, interrupt_source_data, m_out);
    chk({tag, ".busy"}, irq_busy, (m_phase == 2));
    chk({tag, ".drops"}, drop_count, m_drops[7:0]);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    interrupt_key = 0; interrupt_eth = 0; irq_ack = 0; irq_done = 0;
    rst = 1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    cyc({tag, ".held"});
    rst = 0;
  endtask

  task automatic pulse_ack(input string tag);
    irq_ack = 1; cyc(tag); irq_ack = 0;
  endtask

  task automatic pulse_done(input string tag);
    irq_done = 1; cyc(tag); irq_done = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    cyc("reset_cyc");
    rst = 0;

    // Single key event
    irq_enable = 1; key_data = 32'hDEADBEEF; interrupt_key = 1;
    cyc("key_e0");
    chk("key_e0_noint", interrupt, 1'b0);
    cyc("key_e1");
    chk("key_int", interrupt, 1'b1);
    chk("key_cause", irq_cause, 2'b01);
    chk("key_data", interrupt_source_data, 32'hDEADBEEF);
    cyc("key_hold");
    pulse_ack("key_ack");
    chk("key_ack_int", interrupt, 1'b0);
    chk("key_ack_busy", irq_busy, 1'b1);
    cyc("key_svc");
    pulse_done("key_done");
    chk("key_done_cause", irq_cause, 2'b00);
    chk("key_done_busy", irq_busy, 1'b0);
    repeat (3) cyc("key_held_line");
    chk("key_held_noreq", interrupt, 1'b0);

    // Simultaneous sources: eth first, key after one idle cycle
    do_reset("r2");
    irq_enable = 1;
    key_data = 32'h11111111; eth_data = 32'h22222222;
    interrupt_key = 1; interrupt_eth = 1;
    cyc("both_e0");
    interrupt_key = 0; interrupt_eth = 0;
    cyc("both_e1");
    chk("both_cause_eth", irq_cause, 2'b10);
    chk("both_data_eth", interrupt_source_data, 32'h22222222);
    pulse_ack("both_ack");
    pulse_done("both_done");
    chk("both_gap_int", interrupt, 1'b0);
    cyc("both_next");
    chk("both_cause_key", irq_cause, 2'b01);
    chk("both_data_key", interrupt_source_data, 32'h11111111);
    pulse_ack("both_ack2");
    pulse_done("both_done2");

    // First payload wins, drops counted
    do_reset("r3");
    irq_enable = 1;
    key_data = 32'hA; interrupt_key = 1; cyc("drop_a");
    interrupt_key = 0; cyc("drop_a0");
    key_data = 32'hB; interrupt_key = 1; cyc("drop_b");
    interrupt_key = 0; cyc("drop_b0");
    key_data = 32'hC; interrupt_key = 1; cyc("drop_c");
    interrupt_key = 0; cyc("drop_c0");
    chk("drop_two", drop_count, 8'd2);
    chk("drop_first_wins", interrupt_source_data, 32'hA);
    pulse_ack("drop_ack");
    pulse_done("drop_done");

    // Double drop in one cycle, then saturation
    do_reset("r4");
    irq_enable = 0;
    interrupt_key = 1; interrupt_eth = 1; cyc("dd_set");
    interrupt_key = 0; interrupt_eth = 0; cyc("dd_low");
    interrupt_key = 1; interrupt_eth = 1; cyc("dd_drop");
    interrupt_key = 0; interrupt_eth = 0;
    chk("dd_plus2", drop_count, 8'd2);
    for (int i = 0; i < 300; i++) begin
      key_data = i; interrupt_key = 1; cyc("sat_hi");
      interrupt_key = 0; cyc("sat_lo");
    end
    chk("sat_ff", drop_count, 8'hFF);

    // Enable gating and re-presentation
    do_reset("r5");
    irq_enable = 0; eth_data = 32'h5A5A0001; interrupt_eth = 1;
    cyc("en_e0");
    interrupt_eth = 0;
    repeat (3) cyc("en_off");
    chk("en_off_noint", interrupt, 1'b0);
    irq_enable = 1; cyc("en_on");
    chk("en_on_int", interrupt, 1'b1);
    irq_enable = 0; cyc("en_drop");
    chk("en_drop_int", interrupt, 1'b0);
    chk("en_drop_cause", irq_cause, 2'b00);
    irq_enable = 1; cyc("en_again");
    chk("en_again_cause", irq_cause, 2'b10);
    chk("en_again_data", interrupt_source_data, 32'h5A5A0001);
    pulse_ack("en_ack");
    pulse_done("en_done");

    // Event coinciding with ack of the same source
    do_reset("r6");
    irq_enable = 1;
    key_data = 32'h1; interrupt_key = 1; cyc("sa_e0");
    interrupt_key = 0; cyc("sa_e1");
    key_data = 32'h2; interrupt_key = 1; irq_ack = 1; cyc("sa_ack");
    irq_ack = 0; interrupt_key = 0;
    chk("sa_nodrop", drop_count, 8'd0);
    pulse_done("sa_done");
    cyc("sa_gap");
    chk("sa_rereq", interrupt, 1'b1);
    chk("sa_newdata", interrupt_source_data, 32'h2);

    // Reset in SERVICE with eth pending
    do_reset("r7");
    irq_enable = 1;
    eth_data = 32'h77; interrupt_eth = 1; cyc("rs_e0");
    interrupt_eth = 0; cyc("rs_e1");
    pulse_ack("rs_ack");
    eth_data = 32'h88; interrupt_eth = 1; cyc("rs_pend");
    interrupt_eth = 0; cyc("rs_svc");
    rst = 1; #1;
    chk("rs_int", interrupt, 1'b0);
    chk("rs_busy", irq_busy, 1'b0);
    chk("rs_cause", irq_cause, 2'b00);
    chk("rs_data", interrupt_source_data, 32'h0);
    model_reset();
    cyc("rs_held");
    rst = 0;
    repeat (4) cyc("rs_after");
    chk("rs_noreq", interrupt, 1'b0);

    // Random traffic
    do_reset("r8");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) interrupt_key = ~interrupt_key;
      if ($urandom_range(0, 3) == 0) interrupt_eth = ~interrupt_eth;
      key_data   = $urandom;
      eth_data   = $urandom;
      irq_enable = ($urandom_range(0, 9) != 0);
      irq_ack    = ($urandom_range(0, 2) == 0);
      irq_done   = ($urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
